// File: rtl/sonar_scan_ctrl.sv
// rtl/sonar_scan_ctrl.sv - round-robin ultrasonic sensor scanner sharing one echo-measurement unit
module sonar_scan_ctrl #(
  parameter int N_SENS         = 4,
  parameter int TRIG_CYCLES    = 1250,
  parameter int TIMEOUT_CYCLES = 4_750_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_SENS-1:0]    sensor_en,
  input  logic [N_SENS-1:0]    echo_in,
  output logic [N_SENS-1:0]    trig,
  output logic                 echo_mux,
  input  logic [15:0]          dist_in,
  output logic [16*N_SENS-1:0] dist_out,
  output logic [N_SENS-1:0]    tmo_flag,
  output logic [2:0]           cur_idx,
  output logic                 scan_done
);

  localparam int MAX_A   = (TRIG_CYCLES > SETTLE_CYCLES) ? TRIG_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [15:0] DIST_MAX = 16'd9999;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, WAIT_FALL, SETTLE, GAP} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [2:0]        idx_d, nxt_idle, nxt_gap, gap_start;
  logic              done_d, wr_en, wr_tmo;
  logic [15:0]       wr_val;
  logic [N_SENS-1:0] echo_s1, echo_s2, echo_d;
  logic              echo_cur, echo_cur_d, rise, fall;

  // Rotate the mask so the search starts at 'start', then map the offset back modulo N_SENS.
  function automatic logic [2:0] next_enabled(input logic [2:0] start, input logic [N_SENS-1:0] mask);
    logic [2*N_SENS-1:0] dbl;
    logic [2:0]          off;
    logic                found;
    logic [3:0]          sum;
    dbl   = {mask, mask} >> start;
    off   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < N_SENS; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        off   = 3'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= 4'(N_SENS)) sum = sum - 4'(N_SENS);
    return sum[2:0];
  endfunction

  assign gap_start = (cur_idx == 3'(N_SENS - 1)) ? 3'd0 : cur_idx + 3'd1;
  assign nxt_idle  = next_enabled(cur_idx, sensor_en);
  assign nxt_gap   = next_enabled(gap_start, sensor_en);

  always_comb begin
    echo_cur   = 1'b0;
    echo_cur_d = 1'b0;
    echo_mux   = 1'b0;
    trig       = '0;
    for (int i = 0; i < N_SENS; i++) begin
      if (cur_idx == 3'(i)) begin
        echo_cur   = echo_s2[i];
        echo_cur_d = echo_d[i];
        echo_mux   = (state != IDLE) && echo_in[i];
        trig[i]    = (state == TRIG);
      end
    end
  end

  // Edges come from the synchronized history, so an echo already high on WAIT_RISE entry is ignored.
  assign rise = echo_cur & ~echo_cur_d;
  assign fall = ~echo_cur & echo_cur_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    idx_d   = cur_idx;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_tmo  = 1'b0;
    wr_val  = 16'd0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (enable && (|sensor_en)) begin
          idx_d   = nxt_idle;
          state_d = TRIG;
        end
      end
      TRIG: begin
        if (cnt == CW'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = WAIT_FALL;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          wr_en   = 1'b1;
          wr_tmo  = 1'b1;
          wr_val  = DIST_MAX;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          wr_en   = 1'b1;
          wr_tmo  = 1'b1;
          wr_val  = DIST_MAX;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          wr_en   = 1'b1;
          wr_val  = (dist_in > DIST_MAX) ? DIST_MAX : dist_in;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (|sensor_en) begin
            idx_d   = nxt_gap;
            done_d  = (nxt_gap <= cur_idx);
            state_d = enable ? TRIG : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_idx   <= 3'd0;
      scan_done <= 1'b0;
      echo_s1   <= '0;
      echo_s2   <= '0;
      echo_d    <= '0;
      dist_out  <= '0;
      tmo_flag  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cur_idx   <= idx_d;
      scan_done <= done_d;
      echo_s1   <= echo_in;
      echo_s2   <= echo_s1;
      echo_d    <= echo_s2;
      for (int k = 0; k < N_SENS; k++) begin
        if (wr_en && (cur_idx == 3'(k))) begin
          dist_out[16*k +: 16] <= wr_val;
          tmo_flag[k]          <= wr_tmo;
        end
      end
    end
  end

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// tb/tb_sonar_scan_ctrl.sv - scoreboard bench for sonar_scan_ctrl
module tb_sonar_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  sensor_en = 4'd0;
  logic [3:0]  echo_in = 4'd0;
  logic [15:0] dist_in = 16'd0;
  logic [3:0]  trig;
  logic        echo_mux;
  logic [63:0] dist_out;
  logic [3:0]  tmo_flag;
  logic [2:0]  cur_idx;
  logic        scan_done;

  sonar_scan_ctrl #(
    .N_SENS(4), .TRIG_CYCLES(10), .TIMEOUT_CYCLES(200), .GAP_CYCLES(50), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensor_en(sensor_en), .echo_in(echo_in),
    .trig(trig), .echo_mux(echo_mux), .dist_in(dist_in), .dist_out(dist_out),
    .tmo_flag(tmo_flag), .cur_idx(cur_idx), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int idx;
    int val;
    int tmo;
    int lat;
  } res_t;

  int   exp_trig[$];
  res_t exp_res[$];
  int   exp_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: turns trig pulses, result writes and scan_done pulses into scoreboard pops.
  logic [3:0]  prev_trig;
  logic [63:0] prev_dist;
  logic [3:0]  prev_tmo;
  bit          in_pulse = 0;
  int          p_start, p_idx, p_hot;
  int          last_fall = 0;
  int          last_idx = -1;

  always @(negedge clk) begin
    if (rst) begin
      in_pulse  = 0;
      prev_trig = trig;
      prev_dist = dist_out;
      prev_tmo  = tmo_flag;
    end else begin
      if (trig != 4'd0 && prev_trig == 4'd0) begin
        in_pulse = 1;
        p_start  = cyc;
        p_hot    = $countones(trig);
        p_idx    = -1;
        for (int k = 0; k < 4; k++) if (trig[k]) p_idx = k;
      end else if (trig == 4'd0 && prev_trig != 4'd0 && in_pulse) begin
        in_pulse  = 0;
        last_fall = cyc;
        last_idx  = p_idx;
        if (exp_trig.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL trig_unexpected: got pulse on sensor %0d expected none", p_idx);
        end else begin
          int e;
          e = exp_trig.pop_front();
          check("trig_idx", p_idx, e);
          check("trig_width", cyc - p_start, 10);
          check("trig_onehot", p_hot, 1);
        end
      end
      if (dist_out != prev_dist || tmo_flag != prev_tmo) begin
        int ch;
        ch = -1;
        for (int k = 3; k >= 0; k--)
          if (dist_out[16*k +: 16] != prev_dist[16*k +: 16] || tmo_flag[k] != prev_tmo[k]) ch = k;
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: got write on sensor %0d expected none", ch);
        end else begin
          res_t r;
          logic [1:0] c2;
          r  = exp_res.pop_front();
          c2 = ch[1:0];
          check("res_idx", ch, r.idx);
          check("res_dist", dist_out[16*c2 +: 16], r.val);
          check("res_tmo", tmo_flag[c2], r.tmo);
          if (r.lat >= 0) check("res_latency", cyc - last_fall, r.lat);
        end
      end
      if (scan_done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got scan_done after sensor %0d expected none", last_idx);
        end else begin
          check("done_after", last_idx, exp_done.pop_front());
        end
      end
      prev_trig = trig;
      prev_dist = dist_out;
      prev_tmo  = tmo_flag;
    end
  end

  task automatic start_slot();
    int n;
    n = 0;
    enable = 1'b1;
    while (trig == 4'd0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL slot_start: got no trigger expected one within 3000 cycles");
    end
    enable = 1'b0;
  endtask

  task automatic ping(input int idx, input int dly, input int wid, input logic [15:0] d, input int drop_at);
    int n;
    logic [1:0] i2;
    i2 = idx[1:0];
    n  = 0;
    while (trig[i2] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    while (trig[i2] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL ping_wait: got no trigger on sensor %0d expected one", idx);
    end else begin
      dist_in = d;
      repeat (dly) @(negedge clk);
      echo_in[i2] = 1'b1;
      #1 check("echo_mux", echo_mux, 1);
      for (int i = 0; i < wid; i++) begin
        if (i == drop_at) enable = 1'b0;
        @(negedge clk);
      end
      echo_in[i2] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    echo_in = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_done", scan_done, 0);
    check("rst_echo_mux", echo_mux, 0);
    check("rst_dist", dist_out, 0);
    check("rst_tmo", tmo_flag, 0);
    check("rst_idx", cur_idx, 0);
    echo_in = 4'd0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single-sensor ping
    sensor_en = 4'b0001;
    exp_trig.push_back(0);
    exp_res.push_back('{0, 1234, 0, -1});
    exp_done.push_back(0);
    start_slot();
    ping(0, 100, 60, 16'd1234, -1);
    repeat (100) @(negedge clk);

    // No echo: timeout 200 cycles after trigger end
    sensor_en = 4'b0010;
    exp_trig.push_back(1);
    exp_res.push_back('{1, 9999, 1, 200});
    exp_done.push_back(1);
    start_slot();
    repeat (300) @(negedge clk);
    check("idx_after_timeout", cur_idx, 1);

    // Round robin over sensors 1 and 3
    sensor_en = 4'b1010;
    exp_trig.push_back(1); exp_trig.push_back(3); exp_trig.push_back(1); exp_trig.push_back(3);
    exp_res.push_back('{1, 101, 0, -1});
    exp_res.push_back('{3, 303, 0, -1});
    exp_res.push_back('{1, 111, 0, -1});
    exp_res.push_back('{3, 333, 0, -1});
    exp_done.push_back(3); exp_done.push_back(3);
    enable = 1'b1;
    ping(1, 20, 30, 16'd101, -1);
    ping(3, 20, 30, 16'd303, -1);
    ping(1, 20, 30, 16'd111, -1);
    start_slot();
    ping(3, 20, 30, 16'd333, -1);
    repeat (100) @(negedge clk);
    check("idx_after_rr", cur_idx, 1);

    // Clamp of an over-range distance
    sensor_en = 4'b0100;
    exp_trig.push_back(2);
    exp_res.push_back('{2, 9999, 0, -1});
    exp_done.push_back(2);
    start_slot();
    ping(2, 30, 20, 16'd12000, -1);
    repeat (100) @(negedge clk);

    // Enable dropped during WAIT_FALL
    sensor_en = 4'b0001;
    exp_trig.push_back(0);
    exp_res.push_back('{0, 4321, 0, -1});
    exp_done.push_back(0);
    enable = 1'b1;
    ping(0, 10, 40, 16'd4321, 10);
    repeat (300) @(negedge clk);
    check("trig_after_drop", trig, 0);
    check("idx_after_drop", cur_idx, 0);

    // Reset in the middle of a trigger pulse
    sensor_en = 4'b1000;
    start_slot();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_trig", trig, 0);
    check("rst_mid_dist", dist_out, 0);
    check("rst_mid_tmo", tmo_flag, 0);
    check("rst_mid_idx", cur_idx, 0);
    check("rst_mid_done", scan_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    check("left_trig", exp_trig.size(), 0);
    check("left_res", exp_res.size(), 0);
    check("left_done", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
